// File: rtl/mic_pkg.sv
// Shared widths, microinstruction layout and B-bus encoding for the Mic-1 datapath.
package mic_pkg;
  localparam int WORD  = 32;
  localparam int NBITS = 32;
  localparam int ALU   = 8;
  localparam int C     = 9;
  localparam int MEM   = 3;
  localparam int B     = 4;
  localparam int UI_W  = ALU + C + MEM + B;

  localparam int B_LSB   = 0;
  localparam int MEM_LSB = B;
  localparam int C_LSB   = MEM + B;
  localparam int ALU_LSB = C + MEM + B;

  // Register file slots line up with the C-bus enable bit positions.
  localparam int R_MAR = 0;
  localparam int R_MDR = 1;
  localparam int R_PC  = 2;
  localparam int R_SP  = 3;
  localparam int R_LV  = 4;
  localparam int R_CPP = 5;
  localparam int R_TOS = 6;
  localparam int R_OPC = 7;
  localparam int R_H   = 8;
  localparam int NREG  = C;

  typedef enum logic [B-1:0] {
    B_MDR  = 4'd0,
    B_PC   = 4'd1,
    B_MBR  = 4'd2,
    B_MBRU = 4'd3,
    B_SP   = 4'd4,
    B_LV   = 4'd5,
    B_CPP  = 4'd6,
    B_TOS  = 4'd7,
    B_OPC  = 4'd8
  } bsel_e;

  typedef struct packed {
    logic sll8;
    logic sra1;
    logic f0;
    logic f1;
    logic ena;
    logic enb;
    logic inva;
    logic inc;
  } alu_ctl_t;

  typedef struct packed {
    alu_ctl_t     alu;
    logic [C-1:0] c_en;
    logic         write;
    logic         read;
    logic         fetch;
    logic [B-1:0] bsel;
  } uinst_t;

  function automatic logic [WORD-1:0] sext8(input logic [7:0] v);
    return {{(WORD-8){v[7]}}, v};
  endfunction
endpackage

// File: rtl/mic_alu.sv
// Combinational ALU and shifter; flags come from the pre-shift ALU result.
module mic_alu
  import mic_pkg::*;
(
  input  alu_ctl_t        ctl,
  input  logic [WORD-1:0] h,
  input  logic [WORD-1:0] bbus,
  output logic [WORD-1:0] c_bus,
  output logic            n_next,
  output logic            z_next
);
  logic [WORD-1:0] a, bv, f, s;

  always_comb begin
    a = ctl.ena ? h : '0;
    if (ctl.inva) a = ~a;
    bv = ctl.enb ? bbus : '0;
    case ({ctl.f0, ctl.f1})
      2'b00:   f = a & bv;
      2'b01:   f = a | bv;
      2'b10:   f = ~bv;
      default: f = a + bv + {{(WORD-1){1'b0}}, ctl.inc};
    endcase
    s = ctl.sll8 ? (f << 8) : f;
    if (ctl.sra1) s = {s[WORD-1], s[WORD-1:1]};
  end

  assign c_bus  = s;
  assign n_next = f[WORD-1];
  assign z_next = (f == '0);
endmodule

// File: rtl/mic_datapath.sv
// Mic-1 datapath: register file, B mux, ALU/shifter writeback, flags and memory port.
module mic_datapath
  import mic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [UI_W-1:0]  microinst,
  input  logic [WORD-1:0]  mem_in,
  output logic             n,
  output logic             z,
  output logic [NBITS-1:0] mem_addr,
  output logic [WORD-1:0]  mem_out,
  output logic             write_enb
);
  uinst_t ui;
  assign ui = uinst_t'(microinst);

  logic [NREG-1:0][WORD-1:0] rf;
  logic [7:0]                mbr;
  logic [WORD-1:0]           bbus, c_bus;
  logic                      n_next, z_next;
  logic                      rd_en, fetch_en;

  assign rd_en    = ui.read & ~ui.write;
  assign fetch_en = ui.fetch & ~ui.read & ~ui.write;

  always_comb begin
    case (ui.bsel)
      B_MDR:   bbus = rf[R_MDR];
      B_PC:    bbus = rf[R_PC];
      B_MBR:   bbus = sext8(mbr);
      B_MBRU:  bbus = {{(WORD-8){1'b0}}, mbr};
      B_SP:    bbus = rf[R_SP];
      B_LV:    bbus = rf[R_LV];
      B_CPP:   bbus = rf[R_CPP];
      B_TOS:   bbus = rf[R_TOS];
      B_OPC:   bbus = rf[R_OPC];
      default: bbus = '0;
    endcase
  end

  mic_alu u_alu (
    .ctl    (ui.alu),
    .h      (rf[R_H]),
    .bbus   (bbus),
    .c_bus  (c_bus),
    .n_next (n_next),
    .z_next (z_next)
  );

  // A memory read into MDR overrides a C-bus write to MDR in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf  <= '0;
      mbr <= '0;
      n   <= 1'b0;
      z   <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i == R_MDR && rd_en) rf[i] <= mem_in;
        else if (ui.c_en[i])     rf[i] <= c_bus;
      end
      if (fetch_en) mbr <= mem_in[7:0];
      n <= n_next;
      z <= z_next;
    end
  end

  assign mem_addr  = (ui.read | ui.write) ? rf[R_MAR][NBITS-1:0] : rf[R_PC][NBITS-1:0];
  assign mem_out   = rf[R_MDR];
  assign write_enb = ui.write & ~reset;
endmodule

// File: tb/tb_mic_datapath.sv
// Directed bench: each step queues the expected MDR/N/Z and checks them after the edge.
module tb_mic_datapath;
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] microinst;
  logic [31:0] mem_in;
  logic        n, z, write_enb;
  logic [31:0] mem_addr, mem_out;

  mic_datapath dut (
    .clk(clk), .reset(reset), .microinst(microinst), .mem_in(mem_in),
    .n(n), .z(z), .mem_addr(mem_addr), .mem_out(mem_out), .write_enb(write_enb)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] NOP_A  = 8'b0000_0000;
  localparam logic [7:0] PASS_B = 8'b0011_0100;
  localparam logic [7:0] PASS_A = 8'b0011_1000;
  localparam logic [7:0] INC_B  = 8'b0011_0101;
  localparam logic [7:0] SUB_BA = 8'b0011_1111;
  localparam logic [7:0] SRA_A  = 8'b0111_1000;
  localparam logic [7:0] SLSR_A = 8'b1111_1000;
  localparam logic [7:0] SLL_A  = 8'b1011_1000;
  localparam logic [7:0] OR_INC = 8'b0001_1101;
  localparam logic [7:0] NOT_B  = 8'b0010_0100;
  localparam logic [8:0] C_NONE = 9'h000, C_MAR = 9'h001, C_MDR = 9'h002,
                         C_PC = 9'h004, C_SP = 9'h008, C_H = 9'h100;
  localparam logic [2:0] M_NONE = 3'b000, M_WR = 3'b100, M_RD = 3'b010, M_FE = 3'b001;

  typedef struct {
    string       tag;
    logic [31:0] mdr;
    logic        n;
    logic        z;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input string tag, input logic [7:0] alu, input logic [8:0] c,
                       input logic [2:0] mem, input logic [3:0] b, input logic [31:0] mi,
                       input logic [31:0] e_mdr, input logic e_n, input logic e_z);
    exp_t e;
    microinst = {alu, c, mem, b};
    mem_in    = mi;
    e.tag = tag; e.mdr = e_mdr; e.n = e_n; e.z = e_z;
    sbq.push_back(e);
    #1;
  endtask

  task automatic tick;
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      tests++; fails++;
      $error("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sbq.pop_front();
      check32({e.tag, ".mdr"}, mem_out, e.mdr);
      check32({e.tag, ".n"}, {31'b0, n}, {31'b0, e.n});
      check32({e.tag, ".z"}, {31'b0, z}, {31'b0, e.z});
    end
  endtask

  task automatic step(input string tag, input logic [7:0] alu, input logic [8:0] c,
                      input logic [2:0] mem, input logic [3:0] b, input logic [31:0] mi,
                      input logic [31:0] e_mdr, input logic e_n, input logic e_z);
    drive(tag, alu, c, mem, b, mi, e_mdr, e_n, e_z);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    microinst = '0;
    mem_in = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      microinst = $urandom;
      mem_in    = $urandom;
      #1 check32("rst_wenb", {31'b0, write_enb}, 32'd0);
      @(posedge clk);
      #1;
    end
    check32("rst_n", {31'b0, n}, 32'd0);
    check32("rst_z", {31'b0, z}, 32'd0);
    check32("rst_mdr", mem_out, 32'd0);
    reset = 1'b0;

    drive("nop", NOP_A, C_NONE, M_NONE, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    check32("rst_addr", mem_addr, 32'd0);
    check32("nop_wenb", {31'b0, write_enb}, 32'd0);
    tick();
    for (int b = 1; b <= 8; b++)
      if (b != 2 && b != 3)
        step($sformatf("rst_b%0d", b), PASS_B, C_MDR, M_NONE, 4'(b), 32'h0, 32'h0, 1'b0, 1'b1);
    step("rst_h", PASS_A, C_MDR, M_NONE, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    step("rst_mbr", PASS_B, C_MDR, M_NONE, 4'd3, 32'h0, 32'h0, 1'b0, 1'b1);

    step("inc_pc", INC_B, C_PC | C_H, M_NONE, 4'd1, 32'h0, 32'h0, 1'b0, 1'b0);
    drive("inc_nop", NOP_A, C_NONE, M_NONE, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    check32("inc_pc_addr", mem_addr, 32'd1);
    tick();
    step("inc_h", PASS_A, C_MDR, M_NONE, 4'd0, 32'h0, 32'h1, 1'b0, 1'b0);

    step("ld5", NOP_A, C_NONE, M_RD, 4'd0, 32'd5, 32'd5, 1'b0, 1'b1);
    step("h5", PASS_B, C_H, M_NONE, 4'd0, 32'h0, 32'd5, 1'b0, 1'b0);
    step("ld3", NOP_A, C_NONE, M_RD, 4'd0, 32'd3, 32'd3, 1'b0, 1'b1);
    step("sp3", PASS_B, C_SP, M_NONE, 4'd0, 32'h0, 32'd3, 1'b0, 1'b0);
    step("sub_neg", SUB_BA, C_MDR, M_NONE, 4'd4, 32'h0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step("ld3b", NOP_A, C_NONE, M_RD, 4'd0, 32'd3, 32'd3, 1'b0, 1'b1);
    step("h3", PASS_B, C_H, M_NONE, 4'd0, 32'h0, 32'd3, 1'b0, 1'b0);
    step("sub_zero", SUB_BA, C_MDR, M_NONE, 4'd4, 32'h0, 32'h0, 1'b0, 1'b1);

    step("ld10", NOP_A, C_NONE, M_RD, 4'd0, 32'h10, 32'h10, 1'b0, 1'b1);
    step("mar10", PASS_B, C_MAR, M_NONE, 4'd0, 32'h0, 32'h10, 1'b0, 1'b0);
    drive("rd_prio", PASS_B, C_MDR, M_RD, 4'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check32("rd_addr", mem_addr, 32'h10);
    tick();

    step("ld20", NOP_A, C_NONE, M_RD, 4'd0, 32'h20, 32'h20, 1'b0, 1'b1);
    step("pc20", PASS_B, C_PC, M_NONE, 4'd0, 32'h0, 32'h20, 1'b0, 1'b0);
    drive("fetch", NOP_A, C_NONE, M_FE, 4'd0, 32'h0000_00F0, 32'h20, 1'b0, 1'b1);
    check32("fetch_addr", mem_addr, 32'h20);
    tick();
    step("mbr_sx", PASS_B, C_MDR, M_NONE, 4'd2, 32'h0, 32'hFFFF_FFF0, 1'b1, 1'b0);
    step("mbr_zx", PASS_B, C_MDR, M_NONE, 4'd3, 32'h0, 32'h0000_00F0, 1'b0, 1'b0);
    step("b9_zero", PASS_B, C_MDR, M_NONE, 4'd9, 32'h0, 32'h0, 1'b0, 1'b1);

    step("ld8", NOP_A, C_NONE, M_RD, 4'd0, 32'h8, 32'h8, 1'b0, 1'b1);
    step("mar8", PASS_B, C_MAR, M_NONE, 4'd0, 32'h0, 32'h8, 1'b0, 1'b0);
    step("ld1234", NOP_A, C_NONE, M_RD, 4'd0, 32'h1234, 32'h1234, 1'b0, 1'b1);
    drive("wr", NOP_A, C_NONE, M_WR, 4'd0, 32'h0, 32'h1234, 1'b0, 1'b1);
    check32("wr_wenb", {31'b0, write_enb}, 32'd1);
    check32("wr_addr", mem_addr, 32'h8);
    check32("wr_data", mem_out, 32'h1234);
    tick();
    step("wr_rd", NOP_A, C_NONE, M_WR | M_RD, 4'd0, 32'h0BAD, 32'h1234, 1'b0, 1'b1);
    step("wr_fe", NOP_A, C_NONE, M_WR | M_FE, 4'd0, 32'h55, 32'h1234, 1'b0, 1'b1);
    step("mbr_keep", PASS_B, C_MDR, M_NONE, 4'd3, 32'h0, 32'h0000_00F0, 1'b0, 1'b0);

    step("ld8001", NOP_A, C_NONE, M_RD, 4'd0, 32'h8000_0001, 32'h8000_0001, 1'b0, 1'b1);
    step("h8001", PASS_B, C_H, M_NONE, 4'd0, 32'h0, 32'h8000_0001, 1'b1, 1'b0);
    step("sra1", SRA_A, C_MDR, M_NONE, 4'd0, 32'h0, 32'hC000_0000, 1'b1, 1'b0);
    step("sll_sra", SLSR_A, C_MDR, M_NONE, 4'd0, 32'h0, 32'h0000_0080, 1'b1, 1'b0);
    step("sll8", SLL_A, C_MDR, M_NONE, 4'd0, 32'h0, 32'h0000_0100, 1'b1, 1'b0);
    step("or_inc", OR_INC, C_MDR, M_NONE, 4'd1, 32'h0, 32'h8000_0021, 1'b1, 1'b0);
    step("not_b", NOT_B, C_MDR, M_NONE, 4'd1, 32'h0, 32'hFFFF_FFDF, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
